// File: rtl/proc_alu_pkg.sv
//------------------------------------------------------------------------------
// Module   : proc_alu_pkg
// Purpose  : Shared definitions for the iterative datapath ALU: 4-bit
//            function codes, the handshake FSM state type and a helper that
//            tells multi-cycle function codes apart from single-cycle ones.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package proc_alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SLL  = 4'd9;
  localparam logic [3:0] ALU_JALR = 4'd10;
  localparam logic [3:0] ALU_CP0  = 4'd11;
  localparam logic [3:0] ALU_CP1  = 4'd12;
  localparam logic [3:0] ALU_MUL  = 4'd13;
  localparam logic [3:0] ALU_DIV  = 4'd14;
  localparam logic [3:0] ALU_REM  = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // MUL, DIV and REM occupy the top three codes and run iteratively.
  function automatic logic is_iter(input logic [3:0] fn);
    return (fn >= ALU_MUL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/proc_dpath_muldiv_iter.sv
//------------------------------------------------------------------------------
// Module   : proc_dpath_muldiv_iter
// Purpose  : Iterative MUL / DIV / REM engine. A start pulse latches the
//            function and operands; p_nbits iterations follow (shift-add for
//            MUL, restoring divide on magnitudes for DIV/REM). done_o pulses
//            in the final iteration cycle while result_o carries the finished
//            value, so the parent registers it on that edge.
// Ports    : clk, reset      - clock, asynchronous active-high reset
//            start_i         - one-cycle start pulse
//            fn_i            - function code (ALU_MUL / ALU_DIV / ALU_REM)
//            in0_i, in1_i    - operands (sampled only with start_i)
//            done_o          - high in the last iteration cycle
//            result_o        - final result, valid while done_o is high
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module proc_dpath_muldiv_iter
  import proc_alu_pkg::*;
#(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic [3:0]         fn_i,
  input  logic [p_nbits-1:0] in0_i,
  input  logic [p_nbits-1:0] in1_i,
  output logic               done_o,
  output logic [p_nbits-1:0] result_o
);

  localparam int CW = $clog2(p_nbits) + 1;

  logic [CW-1:0]      cnt_q;
  logic               is_mul_q;
  logic               is_div_q;
  logic               neg_quo_q;
  logic               neg_rem_q;
  logic               div0_q;
  // acc: MUL partial product / DIV partial remainder
  // opa: MUL multiplier (shifts right) / DIV dividend shifting into quotient
  // opb: MUL multiplicand (shifts left) / DIV divisor magnitude
  logic [p_nbits-1:0] acc_q, acc_d;
  logic [p_nbits-1:0] opa_q, opa_d;
  logic [p_nbits-1:0] opb_q, opb_d;

  logic [p_nbits-1:0] mul_sum;
  logic [p_nbits:0]   shifted;
  logic [p_nbits:0]   diff;
  logic               ge;
  logic [p_nbits-1:0] rem_step;
  logic [p_nbits-1:0] quo_step;

  function automatic logic [p_nbits-1:0] mag(input logic [p_nbits-1:0] v);
    return v[p_nbits-1] ? -v : v;
  endfunction

  always_comb begin
    mul_sum  = opa_q[0] ? (acc_q + opb_q) : acc_q;
    shifted  = {acc_q, opa_q[p_nbits-1]};
    diff     = shifted - {1'b0, opb_q};
    ge       = ~diff[p_nbits];
    rem_step = ge ? diff[p_nbits-1:0] : shifted[p_nbits-1:0];
    quo_step = {opa_q[p_nbits-2:0], ge};

    if (is_mul_q) begin
      acc_d = mul_sum;
      opa_d = opa_q >> 1;
      opb_d = opb_q << 1;
    end else begin
      acc_d = rem_step;
      opa_d = quo_step;
      opb_d = opb_q;
    end
  end

  // Sign fix-up happens on the step values so the last iteration and the
  // correction land in the same cycle.
  always_comb begin
    result_o = '0;
    if (is_mul_q) begin
      result_o = mul_sum;
    end else if (is_div_q) begin
      if (div0_q)
        result_o = '1;
      else
        result_o = neg_quo_q ? -quo_step : quo_step;
    end else begin
      result_o = neg_rem_q ? -rem_step : rem_step;
    end
  end

  assign done_o = (cnt_q == CW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      is_mul_q  <= 1'b0;
      is_div_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      acc_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
    end else if (start_i) begin
      cnt_q     <= CW'(p_nbits);
      is_mul_q  <= (fn_i == ALU_MUL);
      is_div_q  <= (fn_i == ALU_DIV);
      neg_quo_q <= in0_i[p_nbits-1] ^ in1_i[p_nbits-1];
      neg_rem_q <= in0_i[p_nbits-1];
      div0_q    <= (in1_i == '0);
      acc_q     <= '0;
      if (fn_i == ALU_MUL) begin
        opa_q <= in1_i;
        opb_q <= in0_i;
      end else begin
        opa_q <= mag(in0_i);
        opb_q <= mag(in1_i);
      end
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
      acc_q <= acc_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/proc_dpath_alu_iter.sv
//------------------------------------------------------------------------------
// Module   : proc_dpath_alu_iter
// Purpose  : Handshaked datapath ALU. Single-cycle functions (codes 0-12)
//            return a registered result the cycle after acceptance; MUL, DIV
//            and REM are handed to the iterative engine and return after
//            p_nbits further cycles. Comparison flags come from the operands
//            captured at acceptance.
// Ports    : clk, reset                   - clock, async active-high reset
//            req_val_i / req_rdy_o        - request handshake
//            req_fn_i, req_in0_i/in1_i    - function code and operands
//            resp_val_o / resp_rdy_i      - response handshake
//            resp_out_o                   - result
//            resp_eq_o/resp_lt_o/resp_ltu_o - operand comparison flags
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module proc_dpath_alu_iter
  import proc_alu_pkg::*;
#(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_val_i,
  output logic               req_rdy_o,
  input  logic [3:0]         req_fn_i,
  input  logic [p_nbits-1:0] req_in0_i,
  input  logic [p_nbits-1:0] req_in1_i,
  output logic               resp_val_o,
  input  logic               resp_rdy_i,
  output logic [p_nbits-1:0] resp_out_o,
  output logic               resp_eq_o,
  output logic               resp_lt_o,
  output logic               resp_ltu_o
);

  localparam int p_shamt = $clog2(p_nbits);

  state_e             state_q, state_d;
  logic [p_nbits-1:0] out_q;
  logic               eq_q, lt_q, ltu_q;

  logic               accept;
  logic               iter_start;
  logic               md_done;
  logic [p_nbits-1:0] md_result;

  logic [p_nbits-1:0] sum;
  logic [p_shamt-1:0] shamt;
  logic               in_eq, in_lt, in_ltu;
  logic [p_nbits-1:0] alu_result;

  assign accept     = req_val_i & req_rdy_o;
  assign iter_start = accept & is_iter(req_fn_i);

  proc_dpath_muldiv_iter #(
    .p_nbits (p_nbits)
  ) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .start_i  (iter_start),
    .fn_i     (req_fn_i),
    .in0_i    (req_in0_i),
    .in1_i    (req_in1_i),
    .done_o   (md_done),
    .result_o (md_result)
  );

  // Single-cycle ALU operates directly on the request so its result can be
  // registered on the accept edge.
  always_comb begin
    sum    = req_in0_i + req_in1_i;
    shamt  = req_in1_i[p_shamt-1:0];
    in_eq  = (req_in0_i == req_in1_i);
    in_lt  = ($signed(req_in0_i) < $signed(req_in1_i));
    in_ltu = (req_in0_i < req_in1_i);

    alu_result = '0;
    case (req_fn_i)
      ALU_ADD:  alu_result = sum;
      ALU_SUB:  alu_result = req_in0_i - req_in1_i;
      ALU_AND:  alu_result = req_in0_i & req_in1_i;
      ALU_OR:   alu_result = req_in0_i | req_in1_i;
      ALU_XOR:  alu_result = req_in0_i ^ req_in1_i;
      ALU_SLT:  alu_result = {{(p_nbits-1){1'b0}}, in_lt};
      ALU_SLTU: alu_result = {{(p_nbits-1){1'b0}}, in_ltu};
      ALU_SRA:  alu_result = $unsigned($signed(req_in0_i) >>> shamt);
      ALU_SRL:  alu_result = req_in0_i >> shamt;
      ALU_SLL:  alu_result = req_in0_i << shamt;
      ALU_JALR: alu_result = sum & ~{{(p_nbits-1){1'b0}}, 1'b1};
      ALU_CP0:  alu_result = req_in0_i;
      ALU_CP1:  alu_result = req_in1_i;
      default:  alu_result = '0;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept)     state_d = is_iter(req_fn_i) ? CALC : DONE;
      CALC: if (md_done)    state_d = DONE;
      DONE: if (resp_rdy_i) state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_rdy_o  = (state_q == IDLE);
    resp_val_o = (state_q == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= '0;
      eq_q  <= 1'b0;
      lt_q  <= 1'b0;
      ltu_q <= 1'b0;
    end else begin
      if (accept) begin
        eq_q  <= in_eq;
        lt_q  <= in_lt;
        ltu_q <= in_ltu;
        if (!is_iter(req_fn_i))
          out_q <= alu_result;
      end
      if ((state_q == CALC) && md_done)
        out_q <= md_result;
    end
  end

  assign resp_out_o = out_q;
  assign resp_eq_o  = eq_q;
  assign resp_lt_o  = lt_q;
  assign resp_ltu_o = ltu_q;

endmodule

`default_nettype wire

// File: tb/tb_proc_dpath_alu_iter.sv
//------------------------------------------------------------------------------
// Module   : tb_proc_dpath_alu_iter
// Purpose  : Directed self-checking bench for proc_dpath_alu_iter, with a
//            32-bit instance and a 16-bit instance.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_proc_dpath_alu_iter;

  logic        clk;
  logic        reset;

  logic        req_val, req_rdy, resp_val, resp_rdy;
  logic [3:0]  req_fn;
  logic [31:0] req_in0, req_in1, resp_out;
  logic        resp_eq, resp_lt, resp_ltu;

  logic        s_req_val, s_req_rdy, s_resp_val, s_resp_rdy;
  logic [3:0]  s_req_fn;
  logic [15:0] s_req_in0, s_req_in1, s_resp_out;
  logic        s_resp_eq, s_resp_lt, s_resp_ltu;

  int n_vec;
  int n_err;

  proc_dpath_alu_iter #(.p_nbits(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_val_i  (req_val),
    .req_rdy_o  (req_rdy),
    .req_fn_i   (req_fn),
    .req_in0_i  (req_in0),
    .req_in1_i  (req_in1),
    .resp_val_o (resp_val),
    .resp_rdy_i (resp_rdy),
    .resp_out_o (resp_out),
    .resp_eq_o  (resp_eq),
    .resp_lt_o  (resp_lt),
    .resp_ltu_o (resp_ltu)
  );

  proc_dpath_alu_iter #(.p_nbits(16)) dut16 (
    .clk        (clk),
    .reset      (reset),
    .req_val_i  (s_req_val),
    .req_rdy_o  (s_req_rdy),
    .req_fn_i   (s_req_fn),
    .req_in0_i  (s_req_in0),
    .req_in1_i  (s_req_in1),
    .resp_val_o (s_resp_val),
    .resp_rdy_i (s_resp_rdy),
    .resp_out_o (s_resp_out),
    .resp_eq_o  (s_resp_eq),
    .resp_lt_o  (s_resp_lt),
    .resp_ltu_o (s_resp_ltu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request in IDLE; returns #1 after the accept edge with the
  // request inputs scrambled so later sampling would be visible.
  task automatic send(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
    req_fn  = fn;
    req_in0 = a;
    req_in1 = b;
    req_val = 1'b1;
    @(posedge clk); #1;
    req_val = 1'b0;
    req_fn  = 4'($urandom);
    req_in0 = $urandom;
    req_in1 = $urandom;
  endtask

  task automatic wait_resp(output int cyc);
    cyc = 0;
    while (resp_val !== 1'b1 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic pop();
    resp_rdy = 1'b1;
    @(posedge clk); #1;
    resp_rdy = 1'b0;
  endtask

  task automatic run_one(input string tag, input logic [3:0] fn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    send(fn, a, b);
    chk({tag, "_val"}, 64'(resp_val), 64'd1);
    chk(tag, 64'(resp_out), 64'(exp));
    pop();
  endtask

  task automatic run_iter(input string tag, input logic [3:0] fn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
    int cyc;
    send(fn, a, b);
    wait_resp(cyc);
    chk({tag, "_lat"}, 64'(cyc), 64'd32);
    chk(tag, 64'(resp_out), 64'(exp));
    pop();
  endtask

  task automatic send16(input logic [3:0] fn, input logic [15:0] a, input logic [15:0] b);
    s_req_fn  = fn;
    s_req_in0 = a;
    s_req_in1 = b;
    s_req_val = 1'b1;
    @(posedge clk); #1;
    s_req_val = 1'b0;
  endtask

  task automatic pop16();
    s_resp_rdy = 1'b1;
    @(posedge clk); #1;
    s_resp_rdy = 1'b0;
  endtask

  initial begin
    int cyc;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    req_val = 1'b0; req_fn = '0; req_in0 = '0; req_in1 = '0; resp_rdy = 1'b0;
    s_req_val = 1'b0; s_req_fn = '0; s_req_in0 = '0; s_req_in1 = '0; s_resp_rdy = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_rdy",  64'(req_rdy), 64'd1);
    chk("rst_resp_val", 64'(resp_val), 64'd0);
    chk("rst_out",      64'(resp_out), 64'd0);
    chk("rst_flags",    64'({resp_eq, resp_lt, resp_ltu}), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // ADD 5+3, flags all clear
    send(4'd0, 32'd5, 32'd3);
    chk("add_val",   64'(resp_val), 64'd1);
    chk("add_out",   64'(resp_out), 64'd8);
    chk("add_flags", 64'({resp_eq, resp_lt, resp_ltu}), 64'b000);
    pop();
    chk("add_idle",  64'(req_rdy), 64'd1);

    // SUB 5-(-8): 5 >u 0xFFFFFFF8 is false -> ltu only
    send(4'd1, 32'd5, 32'hFFFF_FFF8);
    chk("sub_out",   64'(resp_out), 64'd13);
    chk("sub_flags", 64'({resp_eq, resp_lt, resp_ltu}), 64'b001);
    pop();

    // Remaining single-cycle codes on one operand pair; shift amount is 5
    run_one("and",  4'd2,  32'hF0F0_1234, 32'h0FF0_8005, 32'h00F0_0004);
    run_one("or",   4'd3,  32'hF0F0_1234, 32'h0FF0_8005, 32'hFFF0_9235);
    run_one("xor",  4'd4,  32'hF0F0_1234, 32'h0FF0_8005, 32'hFF00_9231);
    run_one("slt",  4'd5,  32'hF0F0_1234, 32'h0FF0_8005, 32'h0000_0001);
    run_one("sltu", 4'd6,  32'hF0F0_1234, 32'h0FF0_8005, 32'h0000_0000);
    run_one("sra",  4'd7,  32'hF0F0_1234, 32'h0FF0_8005, 32'hFF87_8091);
    run_one("srl",  4'd8,  32'hF0F0_1234, 32'h0FF0_8005, 32'h0787_8091);
    run_one("sll",  4'd9,  32'hF0F0_1234, 32'h0FF0_8005, 32'h1E02_4680);
    run_one("jalr", 4'd10, 32'hF0F0_1234, 32'h0FF0_8005, 32'h00E0_9238);
    run_one("cp0",  4'd11, 32'hF0F0_1234, 32'h0FF0_8005, 32'hF0F0_1234);
    run_one("cp1",  4'd12, 32'hF0F0_1234, 32'h0FF0_8005, 32'h0FF0_8005);

    // MUL -1*3 with latency and flags (-1 < 3 signed, not unsigned)
    send(4'd13, 32'hFFFF_FFFF, 32'd3);
    chk("mul_busy_rdy", 64'(req_rdy), 64'd0);
    wait_resp(cyc);
    chk("mul_lat",   64'(cyc), 64'd32);
    chk("mul_out",   64'(resp_out), 64'hFFFF_FFFD);
    chk("mul_flags", 64'({resp_eq, resp_lt, resp_ltu}), 64'b010);
    pop();
    run_iter("mul2", 4'd13, 32'h0000_4399, 32'h0000_0100, 32'h0043_9900);

    // DIV / REM signs
    run_iter("div_n7_2",   4'd14, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD);
    run_iter("rem_n7_2",   4'd15, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF);
    run_iter("rem_7_n2",   4'd15, 32'd7,         32'hFFFF_FFFE,  32'd1);
    run_iter("div_100_7",  4'd14, 32'd100,       32'd7,          32'd14);
    run_iter("rem_100_7",  4'd15, 32'd100,       32'd7,          32'd2);
    run_iter("div_n100_n7",4'd14, 32'hFFFF_FF9C, 32'hFFFF_FFF9,  32'd14);

    // Division corners
    run_iter("div0",       4'd14, 32'd100,       32'd0,          32'hFFFF_FFFF);
    run_iter("rem0",       4'd15, 32'd100,       32'd0,          32'd100);
    run_iter("div_ovf",    4'd14, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000);
    run_iter("rem_ovf",    4'd15, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0);

    // Backpressure on SRA by 16 (upper shift bits set, must be ignored);
    // a competing request is held valid while busy and must not be taken.
    send(4'd7, 32'h8000_00AB, 32'hFFFF_FFF0);
    req_val = 1'b1;
    req_fn  = 4'd0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_val", 64'(resp_val), 64'd1);
      chk("bp_out", 64'(resp_out), 64'hFFFF_8000);
      chk("bp_rdy", 64'(req_rdy), 64'd0);
      @(posedge clk); #1;
    end
    req_val = 1'b0;
    pop();
    chk("bp_idle_rdy", 64'(req_rdy), 64'd1);
    chk("bp_idle_val", 64'(resp_val), 64'd0);

    // Reset 10 cycles into a MUL: outputs drop without a clock edge
    send(4'd13, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) @(posedge clk);
    #1;
    chk("mr_pre_val", 64'(resp_val), 64'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("mr_val",  64'(resp_val), 64'd0);
    chk("mr_rdy",  64'(req_rdy), 64'd1);
    chk("mr_out",  64'(resp_out), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("mr_no_resp", 64'(resp_val), 64'd0);

    // SLTU 0x4399 vs -0x778 after recovery
    send(4'd6, 32'h0000_4399, 32'hFFFF_F888);
    chk("sltu2_out",   64'(resp_out), 64'd1);
    chk("sltu2_flags", 64'({resp_eq, resp_lt, resp_ltu}), 64'b001);
    pop();

    // 16-bit instance
    send16(4'd9, 16'hFFFF, 16'hFFFF);
    chk("w16_sll_val", 64'(s_resp_val), 64'd1);
    chk("w16_sll",     64'(s_resp_out), 64'h8000);
    chk("w16_flags",   64'({s_resp_eq, s_resp_lt, s_resp_ltu}), 64'b100);
    pop16();
    send16(4'd10, 16'd200, 16'hFFF1);
    chk("w16_jalr", 64'(s_resp_out), 64'd184);
    pop16();
    send16(4'd14, 16'hFFF9, 16'd2);
    cyc = 0;
    while (s_resp_val !== 1'b1 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("w16_div_lat", 64'(cyc), 64'd16);
    chk("w16_div",     64'(s_resp_out), 64'hFFFD);
    pop16();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
